// File: rtl/ece571_alu_pipe.sv
// rtl/ece571_alu_pipe.sv - three-stage ALU execute pipeline with 16 x N register file
// Build option: FORWARD_EN selects S3->S2 operand forwarding instead of a one-cycle RAW stall.

package ece571_cpu_pkg;
   parameter int N = 32;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;

   // instruction[7] is the immediate flag, instruction[6:0] is the trace tag
   typedef struct packed {
      logic [2:0]   opcode;
      logic         we;
      logic [3:0]   rd;
      logic [3:0]   rs1;
      logic [3:0]   rs2;
      logic [7:0]   instruction;
      logic [N-1:0] data;
   } alu_instruction;
endpackage

module ece571_alu_pipe
   import ece571_cpu_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  alu_instruction in_instr,
   output logic           res_valid,
   output logic [3:0]     res_rd,
   output logic [N-1:0]   res_data,
   output logic           res_we,
   output logic [6:0]     res_tag,
   output logic           res_illegal
);

`ifdef FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic [N-1:0]   rf_q [16];
   logic [N-1:0]   rf_d [16];

   logic           s1_valid_q, s1_valid_d;
   alu_instruction s1_instr_q, s1_instr_d;

   logic           s2_valid_q, s2_valid_d;
   logic [2:0]     s2_op_q, s2_op_d;
   logic           s2_wr_q, s2_wr_d;
   logic [3:0]     s2_rd_q, s2_rd_d;
   logic [3:0]     s2_rs1_q, s2_rs1_d;
   logic [3:0]     s2_rs2_q, s2_rs2_d;
   logic           s2_use_rs2_q, s2_use_rs2_d;
   logic [6:0]     s2_tag_q, s2_tag_d;
   logic [N-1:0]   s2_a_q, s2_a_d;
   logic [N-1:0]   s2_b_q, s2_b_d;

   logic           res_valid_q, res_valid_d;
   logic [3:0]     res_rd_q, res_rd_d;
   logic [N-1:0]   res_data_q, res_data_d;
   logic           res_we_q, res_we_d;
   logic [6:0]     res_tag_q, res_tag_d;
   logic           res_illegal_q, res_illegal_d;

   logic           s1_use_rs2, s1_legal, hazard, stall;
   logic           fwd_a, fwd_b, s2_legal;
   logic [N-1:0]   op_a, op_b, alu_y;

   // s2_wr_q already implies rd != 0 and a legal opcode
   always_comb begin
      s1_use_rs2 = ~s1_instr_q.instruction[7];
      s1_legal   = s1_instr_q.opcode <= 3'd4;
      hazard     = s1_valid_q && s2_valid_q && s2_wr_q &&
                   ((s1_instr_q.rs1 == s2_rd_q) ||
                    (s1_use_rs2 && (s1_instr_q.rs2 == s2_rd_q)));
      stall      = hazard && !FWD;
   end

   assign in_ready = !stall;

   always_comb begin
      fwd_a    = FWD && res_valid_q && res_we_q && (res_rd_q == s2_rs1_q);
      fwd_b    = FWD && res_valid_q && res_we_q && s2_use_rs2_q && (res_rd_q == s2_rs2_q);
      op_a     = fwd_a ? res_data_q : s2_a_q;
      op_b     = fwd_b ? res_data_q : s2_b_q;
      s2_legal = s2_op_q <= 3'd4;
      case (s2_op_q)
         OP_ADD:  alu_y = op_a + op_b;
         OP_SUB:  alu_y = op_a - op_b;
         OP_AND:  alu_y = op_a & op_b;
         OP_OR:   alu_y = op_a | op_b;
         OP_XOR:  alu_y = op_a ^ op_b;
         default: alu_y = '0;
      endcase
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_instr_d = s1_instr_q;
      if (!stall) begin
         s1_valid_d = in_valid;
         s1_instr_d = in_valid ? in_instr : '0;
      end

      s2_valid_d   = s1_valid_q && !stall;
      s2_op_d      = '0;
      s2_wr_d      = 1'b0;
      s2_rd_d      = '0;
      s2_rs1_d     = '0;
      s2_rs2_d     = '0;
      s2_use_rs2_d = 1'b0;
      s2_tag_d     = '0;
      s2_a_d       = '0;
      s2_b_d       = '0;
      if (s2_valid_d) begin
         s2_op_d      = s1_instr_q.opcode;
         s2_wr_d      = s1_instr_q.we && (s1_instr_q.rd != 4'd0) && s1_legal;
         s2_rd_d      = s1_instr_q.rd;
         s2_rs1_d     = s1_instr_q.rs1;
         s2_rs2_d     = s1_instr_q.rs2;
         s2_use_rs2_d = s1_use_rs2;
         s2_tag_d     = s1_instr_q.instruction[6:0];
         s2_a_d       = rf_q[s1_instr_q.rs1];
         s2_b_d       = s1_use_rs2 ? rf_q[s1_instr_q.rs2] : s1_instr_q.data;
      end

      res_valid_d   = s2_valid_q;
      res_rd_d      = s2_valid_q ? s2_rd_q : 4'd0;
      res_data_d    = s2_valid_q ? alu_y : '0;
      res_we_d      = s2_valid_q && s2_wr_q;
      res_tag_d     = s2_valid_q ? s2_tag_q : 7'd0;
      res_illegal_d = s2_valid_q && !s2_legal;

      rf_d = rf_q;
      if (s2_valid_q && s2_wr_q) rf_d[s2_rd_q] = alu_y;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_q          <= '{default: '0};
         s1_valid_q    <= 1'b0;
         s1_instr_q    <= '0;
         s2_valid_q    <= 1'b0;
         s2_op_q       <= '0;
         s2_wr_q       <= 1'b0;
         s2_rd_q       <= '0;
         s2_rs1_q      <= '0;
         s2_rs2_q      <= '0;
         s2_use_rs2_q  <= 1'b0;
         s2_tag_q      <= '0;
         s2_a_q        <= '0;
         s2_b_q        <= '0;
         res_valid_q   <= 1'b0;
         res_rd_q      <= '0;
         res_data_q    <= '0;
         res_we_q      <= 1'b0;
         res_tag_q     <= '0;
         res_illegal_q <= 1'b0;
      end else begin
         rf_q          <= rf_d;
         s1_valid_q    <= s1_valid_d;
         s1_instr_q    <= s1_instr_d;
         s2_valid_q    <= s2_valid_d;
         s2_op_q       <= s2_op_d;
         s2_wr_q       <= s2_wr_d;
         s2_rd_q       <= s2_rd_d;
         s2_rs1_q      <= s2_rs1_d;
         s2_rs2_q      <= s2_rs2_d;
         s2_use_rs2_q  <= s2_use_rs2_d;
         s2_tag_q      <= s2_tag_d;
         s2_a_q        <= s2_a_d;
         s2_b_q        <= s2_b_d;
         res_valid_q   <= res_valid_d;
         res_rd_q      <= res_rd_d;
         res_data_q    <= res_data_d;
         res_we_q      <= res_we_d;
         res_tag_q     <= res_tag_d;
         res_illegal_q <= res_illegal_d;
      end
   end

   assign res_valid   = res_valid_q;
   assign res_rd      = res_rd_q;
   assign res_data    = res_data_q;
   assign res_we      = res_we_q;
   assign res_tag     = res_tag_q;
   assign res_illegal = res_illegal_q;

endmodule

// File: tb/tb_ece571_alu_pipe.sv
// tb/tb_ece571_alu_pipe.sv - directed self-checking bench for ece571_alu_pipe
// Expected RAW timing follows FORWARD_EN when the bench is built with it.

module tb_ece571_alu_pipe;
   import ece571_cpu_pkg::*;

   logic           clk = 1'b0;
   logic           reset;
   logic           in_valid;
   logic           in_ready;
   alu_instruction in_instr;
   logic           res_valid;
   logic [3:0]     res_rd;
   logic [N-1:0]   res_data;
   logic           res_we;
   logic [6:0]     res_tag;
   logic           res_illegal;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int low_cnt = 0;

   typedef struct {
      logic [3:0]   rd;
      logic [N-1:0] data;
      logic         we;
      logic [6:0]   tag;
      logic         ill;
      int           cyc;
   } res_t;
   res_t q[$];

`ifdef FORWARD_EN
   localparam int EXP_GAP  = 1;
   localparam int EXP_LOWS = 0;
`else
   localparam int EXP_GAP  = 2;
   localparam int EXP_LOWS = 1;
`endif

   ece571_alu_pipe dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .res_valid   (res_valid),
      .res_rd      (res_rd),
      .res_data    (res_data),
      .res_we      (res_we),
      .res_tag     (res_tag),
      .res_illegal (res_illegal)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (res_valid) q.push_back('{res_rd, res_data, res_we, res_tag, res_illegal, cyc});
      if (!in_ready) low_cnt = low_cnt + 1;
   end

   function automatic alu_instruction mk(input logic [2:0] op, input logic imm, input logic [6:0] tag,
                                         input logic we, input logic [3:0] rd, input logic [3:0] rs1,
                                         input logic [3:0] rs2, input logic [N-1:0] d);
      alu_instruction i;
      i.opcode      = op;
      i.we          = we;
      i.rd          = rd;
      i.rs1         = rs1;
      i.rs2         = rs2;
      i.instruction = {imm, tag};
      i.data        = d;
      return i;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input alu_instruction i, output int waits);
      bit rdy;
      rdy      = 1'b0;
      waits    = 0;
      in_instr = i;
      in_valid = 1'b1;
      for (int t = 0; t < 8; t++) begin
         rdy = in_ready;
         @(posedge clk);
         #1;
         if (rdy) break;
         waits++;
      end
      in_valid = 1'b0;
      chk("accept", 32'(rdy), 32'd1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic get_res(input string tag, output res_t r);
      int n;
      n = 0;
      while (q.size() == 0 && n < 30) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk({tag, " present"}, 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) r = q.pop_front();
      else r = '{4'hx, 'x, 1'bx, 7'hx, 1'bx, -1};
   endtask

   task automatic read_reg(input logic [3:0] r, input logic [N-1:0] exp);
      int   w;
      res_t rr;
      send(mk(OP_OR, 1'b0, 7'h7f, 1'b0, 4'd0, r, 4'd0, '0), w);
      get_res("read", rr);
      chk($sformatf("read r%0d", r), rr.data, exp);
   endtask

   initial begin
      int              w, w2, base;
      res_t            ra, rb;
      logic [2:0]      ops [5];
      logic [N-1:0]    exp_ops [5];

      ops     = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
      exp_ops = '{32'hFFFF_FFFF, 32'h0000_001F, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

      reset    = 1'b1;
      in_valid = 1'b0;
      in_instr = '0;
      #1;
      chk("rst res_valid", 32'(res_valid), 32'd0);
      chk("rst res_rd", 32'(res_rd), 32'd0);
      chk("rst res_data", res_data, 32'd0);
      chk("rst res_we", 32'(res_we), 32'd0);
      chk("rst res_tag", 32'(res_tag), 32'd0);
      chk("rst res_illegal", 32'(res_illegal), 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;

      // r0 destination and we=0
      send(mk(OP_OR, 1'b1, 7'h10, 1'b1, 4'd0, 4'd0, 4'd0, 32'd7), w);
      get_res("r0 write", ra);
      chk("r0 write data", ra.data, 32'd7);
      chk("r0 write we", 32'(ra.we), 32'd0);
      send(mk(OP_OR, 1'b1, 7'h11, 1'b0, 4'd3, 4'd0, 4'd0, 32'd9), w);
      get_res("we0", ra);
      chk("we0 data", ra.data, 32'd9);
      chk("we0 we", 32'(ra.we), 32'd0);
      read_reg(4'd0, 32'd0);
      read_reg(4'd3, 32'd0);

      // immediate loads then all five ops
      send(mk(OP_OR, 1'b1, 7'h01, 1'b1, 4'd1, 4'd0, 4'd0, 32'h0000_000F), w);
      get_res("ld r1", ra);
      chk("ld r1 data", ra.data, 32'h0000_000F);
      chk("ld r1 we", 32'(ra.we), 32'd1);
      send(mk(OP_OR, 1'b1, 7'h02, 1'b1, 4'd2, 4'd0, 4'd0, 32'hFFFF_FFF0), w);
      get_res("ld r2", ra);
      chk("ld r2 data", ra.data, 32'hFFFF_FFF0);
      for (int k = 0; k < 5; k++) begin
         send(mk(ops[k], 1'b0, 7'(8'h30 + k), 1'b1, 4'(3 + k), 4'd1, 4'd2, '0), w);
         idle(2);
         get_res("op", ra);
         chk($sformatf("op%0d data", k), ra.data, exp_ops[k]);
         chk($sformatf("op%0d rd", k), 32'(ra.rd), 32'(3 + k));
         chk($sformatf("op%0d tag", k), 32'(ra.tag), 32'(8'h30 + k));
      end
      read_reg(4'd4, 32'h0000_001F);

      // wrap-around
      send(mk(OP_OR, 1'b1, 7'h40, 1'b1, 4'd1, 4'd0, 4'd0, 32'hFFFF_FFFF), w);
      get_res("wrap ld", ra);
      chk("wrap ld data", ra.data, 32'hFFFF_FFFF);
      send(mk(OP_ADD, 1'b1, 7'h41, 1'b1, 4'd8, 4'd1, 4'd0, 32'd1), w);
      get_res("wrap add", ra);
      chk("wrap add data", ra.data, 32'h0000_0000);
      send(mk(OP_SUB, 1'b1, 7'h42, 1'b1, 4'd9, 4'd0, 4'd0, 32'd1), w);
      get_res("wrap sub", ra);
      chk("wrap sub data", ra.data, 32'hFFFF_FFFF);

      // back-to-back RAW
      idle(3);
      base = low_cnt;
      send(mk(OP_OR, 1'b1, 7'h20, 1'b1, 4'd1, 4'd0, 4'd0, 32'd5), w);
      send(mk(OP_ADD, 1'b0, 7'h21, 1'b1, 4'd2, 4'd1, 4'd1, '0), w2);
      get_res("raw a", ra);
      get_res("raw b", rb);
      chk("raw a data", ra.data, 32'd5);
      chk("raw b data", rb.data, 32'd10);
      chk("raw b tag", 32'(rb.tag), 32'h21);
      chk("raw gap", 32'(rb.cyc - ra.cyc), 32'(EXP_GAP));
      chk("raw in_ready lows", 32'(low_cnt - base), 32'(EXP_LOWS));
      chk("raw b issue waits", 32'(w2), 32'd0);

      // illegal opcode followed by an immediate read of its rd
      idle(3);
      base = low_cnt;
      send(mk(3'b110, 1'b0, 7'h55, 1'b1, 4'd4, 4'd1, 4'd2, '0), w);
      send(mk(OP_OR, 1'b0, 7'h56, 1'b0, 4'd0, 4'd4, 4'd0, '0), w2);
      get_res("ill", ra);
      get_res("ill next", rb);
      chk("ill flag", 32'(ra.ill), 32'd1);
      chk("ill data", ra.data, 32'd0);
      chk("ill we", 32'(ra.we), 32'd0);
      chk("ill tag", 32'(ra.tag), 32'h55);
      chk("ill next r4", rb.data, 32'h0000_001F);
      chk("ill next flag", 32'(rb.ill), 32'd0);
      chk("ill next gap", 32'(rb.cyc - ra.cyc), 32'd1);
      chk("ill in_ready lows", 32'(low_cnt - base), 32'd0);

      // reset with three instructions in flight
      idle(3);
      chk("queue empty pre-reset", 32'(q.size()), 32'd0);
      send(mk(OP_OR, 1'b1, 7'h61, 1'b1, 4'd1, 4'd0, 4'd0, 32'hA1), w);
      send(mk(OP_OR, 1'b1, 7'h62, 1'b1, 4'd2, 4'd0, 4'd0, 32'hA2), w);
      send(mk(OP_OR, 1'b1, 7'h63, 1'b1, 4'd3, 4'd0, 4'd0, 32'hA3), w);
      chk("pre-reset res_valid", 32'(res_valid), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("mid rst res_valid", 32'(res_valid), 32'd0);
      chk("mid rst res_data", res_data, 32'd0);
      chk("mid rst res_rd", 32'(res_rd), 32'd0);
      chk("mid rst res_we", 32'(res_we), 32'd0);
      chk("mid rst res_tag", 32'(res_tag), 32'd0);
      chk("mid rst in_ready", 32'(in_ready), 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      idle(6);
      chk("no res after reset", 32'(q.size()), 32'd0);
      for (int r = 1; r < 16; r++) read_reg(4'(r), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ece571_alu_pipe.md
# ece571_alu_pipe

Three-stage execute pipeline that consumes the `alu_instruction` stream defined in `ece571_cpu_pkg` and sits directly downstream of instruction issue. It holds the 16 x N architectural register file, reads operands, performs the opcode, and writes back. Results are also presented on a write-back bus for the retire/trace logic. Read-after-write hazards between adjacent instructions are resolved either by forwarding or by a one-cycle stall (see Configuration).

## Interface
- N, default 32 (from `ece571_cpu_pkg::N`): datapath and register width.
- clk, input, 1: single clock; all state is updated on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: `in_instr` is valid.
- in_ready, output, 1: the stage accepts `in_instr` this cycle.
- in_instr, input, `alu_instruction`: the instruction to execute.
- res_valid, output, 1: one-cycle pulse; a result retired this cycle.
- res_rd, output, 4: destination register of the retired result.
- res_data, output, N: ALU result.
- res_we, output, 1: the result was written to the register file.
- res_tag, output, 7: `instruction[6:0]` passed through unchanged.
- res_illegal, output, 1: the opcode was not one of ADD, SUB, AND, OR or XOR.

## Operation
- Field use:
  - `instruction[7]` = imm flag. When it is 1, operand B = `data[N-1:0]`; when it is 0, operand B = reg[rs2].
  - Operand A is always reg[rs1].
- r0 reads as 0. Writes to r0 are discarded, and `res_we` is 0 for them.
- Pipeline stages:
  - S1 (decode) captures on accept (`in_valid && in_ready`).
  - Operands are read combinationally from the register file while the instruction is in S1. They are captured into S2 at the next edge.
  - The ALU evaluates while the instruction is in S2. At the next edge the result is registered into S3. On that same edge the register file is written if `we`, `rd != 0` and the opcode is legal.
  - S3 drives the `res_*` outputs.
- Arithmetic: ADD and SUB are mod 2^N and carry/borrow is discarded. AND, OR and XOR are bitwise.
- Illegal opcodes (3'b101–3'b111):
  - `res_data` = 0, `res_illegal` = 1, `res_we` = 0, and there is no register write.
  - The pipeline continues.
- Hazard: a hazard exists when B is in S1, A is in S2, A will write rd ≠ 0, and B reads that register. Register reads are rs1 always, and rs2 only when the imm flag is 0.
- Bubbles (empty stages) flow through the pipeline with `res_valid` = 0.
- Reset, at any time including mid-operation:
  - All stage valids are cleared immediately and all registers are cleared to 0.
  - In-flight instructions are dropped and produce no write-back.
- Reset values: `res_valid`, `res_rd`, `res_data`, `res_we`, `res_tag` and `res_illegal` are all 0. `in_ready` is 1.

## Timing
- An instruction accepted at edge k produces `res_valid` = 1 during the cycle after edge k+2. Its register write is visible to reads starting in the cycle after edge k+2.
- Throughput is one instruction per cycle when there is no stall.
- `in_ready` depends combinationally on S1/S2 state only, never on `in_valid`.
- `in_instr` must be held stable while `in_valid && !in_ready`.
- An instruction two or more slots behind its producer reads the already-written register file, so no hazard logic is needed for it.
- There is no output backpressure. The `res_*` outputs hold for exactly one cycle per instruction.

## Configuration
- FORWARD_EN defined:
  - Each S2 operand is replaced by the S3 result when S3 is valid, S3 will write, and S3 rd equals the source register (≠ 0).
  - There are never any stalls, and `in_ready` is constantly 1 after reset.
- FORWARD_EN undefined:
  - On a hazard, the instruction in S1 is held and a bubble is inserted into S2. `in_ready` = 0 for that cycle.
  - The next cycle re-reads the register file with the producer already written.
  - Each hazard costs exactly one cycle.

## Test plan
- **Reset:**
  - Stimulus: assert `reset` mid-stream with 3 instructions in flight.
  - Required response: all outputs go to 0 asynchronously. No `res_valid` appears after deassertion. r1..r15 read back as 0.
- **Immediate load plus all ops:**
  - Stimulus: `r1 = r0 | imm 0x0000_000F`, then `r2 = r0 | imm 0xFFFF_FFF0`, then ADD/SUB/AND/OR/XOR of r1 and r2 into r3–r7, spaced by 2 idle cycles.
  - Required response: `res_data` = 0xFFFF_FFFF, 0x0000_001F, 0x0000_0000, 0xFFFF_FFFF, 0xFFFF_FFFF.
- **Wrap-around:**
  - Stimulus: `r1 = 0xFFFF_FFFF`, then r1 + imm 1, then r0 − imm 1.
  - Required response: `res_data` = 0x0000_0000, then 0xFFFF_FFFF.
- **Back-to-back RAW:**
  - Stimulus: `r1 = r0 | imm 5`, immediately followed by `r2 = r1 + r1`.
  - Required response: `res_data` = 10.
  - With FORWARD_EN: the results are on consecutive cycles and `in_ready` never drops.
  - Without FORWARD_EN: `in_ready` = 0 for exactly one cycle and a one-cycle gap separates the two `res_valid` pulses.
- **r0 and `we` = 0:**
  - Stimulus: `r0 = r0 | imm 7` with `we` = 1, then `r3 = r0 | imm 9` with `we` = 0, then read r0 and r3.
  - Required response: `res_we` = 0 both times, and both registers still read 0.
- **Illegal opcode:**
  - Stimulus: opcode 3'b110 with `we` = 1, rd = r4, tag 0x55.
  - Required response: `res_illegal` = 1, `res_data` = 0, `res_we` = 0, `res_tag` = 0x55, and r4 is unchanged. The next instruction issues with no stall.
